// File: rtl/dm_sba_engine.sv
// RISC-V debug System Bus Access engine: owns sbcs/sbaddress/sbdata and runs one
// host-bus transfer at a time for the debugger over a req/gnt/rvalid port.
module dm_sba_engine #(
    parameter int unsigned BusWidth   = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TimeoutCyc = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,
    input  logic                  sbcs_we_i,
    input  logic                  sbaddr0_we_i,
    input  logic                  sbaddr1_we_i,
    input  logic                  sbdata0_we_i,
    input  logic                  sbdata1_we_i,
    input  logic                  sbdata0_re_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           sbcs_o,
    output logic [AddrWidth-1:0]  sbaddr_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [AddrWidth-1:0]  bus_addr_o,
    output logic [BusWidth/8-1:0] bus_be_o,
    output logic [BusWidth-1:0]   bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [BusWidth-1:0]   bus_rdata_i,
    input  logic                  bus_err_i
);

    localparam int NBytes  = int'(BusWidth / 8);
    localparam int OffW    = $clog2(NBytes);
    localparam int MaxAcc  = $clog2(NBytes);
    localparam int TmoW    = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
    localparam int TmoLast = (TimeoutCyc > 0) ? int'(TimeoutCyc) - 1 : 0;

    typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} sba_state_e;

    sba_state_e           r_state, w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic [BusWidth-1:0]  r_data;
    logic                 r_busyerr;
    logic [2:0]           r_err;
    logic                 r_rdonaddr, r_autoinc, r_rdondata;
    logic [2:0]           r_access;
    logic [TmoW-1:0]      r_tmo;

    logic                 w_busy, w_blocked, w_trig_rd, w_trig, w_progress, w_tmo_exp;
    logic                 w_set_busyerr, w_err_set;
    logic [2:0]           w_err_val;
    logic [63:0]          w_a64, w_d64;
    logic [AddrWidth-1:0] w_addr_wr, w_start_addr;
    logic [BusWidth-1:0]  w_data_wr, w_rd_shift, w_rd_data, w_wdata;
    logic [NBytes-1:0]    w_be;
    logic                 w_size_bad, w_misal;
    int                   w_off, w_sz;

    assign w_busy    = (r_state != Idle);
    assign w_blocked = r_busyerr | (r_err != 3'd0);
    assign w_trig_rd = (sbaddr0_we_i & r_rdonaddr) | (sbdata0_re_i & r_rdondata);
    assign w_trig    = w_trig_rd | sbdata0_we_i;
    assign w_off     = int'(r_addr[OffW-1:0]);
    assign w_sz      = 32'd1 << r_access;

    // Register-write images; the halves not present at this width fall off in the cast.
    always_comb begin
        w_a64 = 64'(r_addr);
        if (sbaddr0_we_i) w_a64[31:0] = wdata_i;
        else              w_a64[63:32] = wdata_i;
        w_addr_wr = AddrWidth'(w_a64);
        w_d64 = 64'(r_data);
        if (sbdata0_we_i) w_d64[31:0] = wdata_i;
        else              w_d64[63:32] = wdata_i;
        w_data_wr = BusWidth'(w_d64);
    end

    // A read-on-addr trigger is checked against the address being written.
    assign w_start_addr = sbaddr0_we_i ? w_addr_wr : r_addr;
    assign w_size_bad   = (r_access > 3'(MaxAcc)) || (r_access > 3'd4);
    assign w_misal      = |(w_start_addr & AddrWidth'((64'd1 << r_access) - 64'd1));

    assign w_progress = ((r_state == Read || r_state == Write) && bus_gnt_i) ||
                        ((r_state == WaitRead || r_state == WaitWrite) && bus_rvalid_i);
    assign w_tmo_exp  = (TimeoutCyc != 0) && w_busy && !w_progress &&
                        (r_tmo == TmoW'(TmoLast));
    assign w_set_busyerr = w_busy & (w_trig | sbaddr0_we_i | sbaddr1_we_i |
                                     sbdata0_we_i | sbdata1_we_i);

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_val   = 3'd0;
        unique case (r_state)
            Idle: begin
                if (w_trig && !w_blocked) begin
                    if (w_size_bad) begin
                        w_err_set = 1'b1;
                        w_err_val = 3'd4;
                    end else if (w_misal) begin
                        w_err_set = 1'b1;
                        w_err_val = 3'd3;
                    end else begin
                        w_state_nxt = w_trig_rd ? Read : Write;
                    end
                end
            end
            Read:      if (bus_gnt_i) w_state_nxt = WaitRead;
            Write:     if (bus_gnt_i) w_state_nxt = WaitWrite;
            WaitRead,
            WaitWrite: if (bus_rvalid_i) w_state_nxt = Idle;
            default:   w_state_nxt = Idle;
        endcase
        if (w_tmo_exp) begin
            w_state_nxt = Idle;
            w_err_set   = 1'b1;
            w_err_val   = 3'd1;
        end
        if (bus_rvalid_i && bus_err_i && (r_state == WaitRead || r_state == WaitWrite)) begin
            w_err_set = 1'b1;
            w_err_val = 3'd2;
        end
    end

    // Lane handling: pick the addressed lane on read, replicate the datum on write.
    always_comb begin
        w_rd_shift = bus_rdata_i >> (8 * w_off);
        w_rd_data  = '0;
        w_wdata    = '0;
        w_be       = '0;
        for (int i = 0; i < NBytes; i++) begin
            if (i < w_sz) w_rd_data[i*8 +: 8] = w_rd_shift[i*8 +: 8];
            w_wdata[i*8 +: 8] = r_data[(i & (w_sz - 1)) * 8 +: 8];
            w_be[i] = (i >= w_off) && (i < w_off + w_sz);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dmactive_i) begin
            r_state    <= Idle;
            r_addr     <= '0;
            r_data     <= '0;
            r_busyerr  <= 1'b0;
            r_err      <= 3'd0;
            r_rdonaddr <= 1'b0;
            r_access   <= 3'd2;
            r_autoinc  <= 1'b0;
            r_rdondata <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= (!w_busy || w_progress) ? '0 : r_tmo + 1'b1;
            if (sbcs_we_i) begin
                r_busyerr  <= r_busyerr & ~wdata_i[22];
                r_err      <= r_err & ~wdata_i[14:12];
                r_rdonaddr <= wdata_i[20];
                r_access   <= wdata_i[19:17];
                r_autoinc  <= wdata_i[16];
                r_rdondata <= wdata_i[15];
            end
            if (w_set_busyerr) r_busyerr <= 1'b1;
            if (!w_busy && (sbaddr0_we_i || sbaddr1_we_i)) r_addr <= w_addr_wr;
            if (!w_busy && (sbdata0_we_i || sbdata1_we_i)) r_data <= w_data_wr;
            if (bus_rvalid_i && !bus_err_i && (r_state == WaitRead || r_state == WaitWrite)) begin
                if (r_state == WaitRead) r_data <= w_rd_data;
                if (r_autoinc) r_addr <= r_addr + AddrWidth'(w_sz);
            end
            if (w_err_set) r_err <= w_err_val;
        end
    end

    always_comb begin
        sbcs_o        = '0;
        sbcs_o[31:29] = 3'd1;
        sbcs_o[22]    = r_busyerr;
        sbcs_o[21]    = w_busy;
        sbcs_o[20]    = r_rdonaddr;
        sbcs_o[19:17] = r_access;
        sbcs_o[16]    = r_autoinc;
        sbcs_o[15]    = r_rdondata;
        sbcs_o[14:12] = r_err;
        sbcs_o[11:5]  = 7'(AddrWidth);
        sbcs_o[4]     = (BusWidth >= 128);
        sbcs_o[3]     = (BusWidth >= 64);
        sbcs_o[2:0]   = 3'b111;
    end

    assign sbaddr_o    = r_addr;
    assign sbdata_o    = r_data;
    assign bus_req_o   = (r_state == Read) || (r_state == Write);
    assign bus_we_o    = (r_state == Write) || (r_state == WaitWrite);
    assign bus_addr_o  = r_addr;
    assign bus_be_o    = w_busy ? w_be : '0;
    assign bus_wdata_o = bus_we_o ? w_wdata : '0;

endmodule

// File: tb/tb_dm_sba_engine.sv
// Directed bench for dm_sba_engine at default parameters (32-bit bus/address, 255-cycle timeout).
module tb_dm_sba_engine;

    logic        clk = 1'b0;
    logic        rst, dmactive;
    logic        sbcs_we, sbaddr0_we, sbaddr1_we, sbdata0_we, sbdata1_we, sbdata0_re;
    logic [31:0] wdata;
    logic [31:0] sbcs, sbaddr, sbdata;
    logic        req, we;
    logic [31:0] baddr, bwdata, rdata;
    logic [3:0]  be;
    logic        gnt, rvalid, berr;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  be_exp [4] = '{4'h8, 4'h1, 4'h2, 4'h4};

    dm_sba_engine dut (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbcs_we_i(sbcs_we), .sbaddr0_we_i(sbaddr0_we), .sbaddr1_we_i(sbaddr1_we),
        .sbdata0_we_i(sbdata0_we), .sbdata1_we_i(sbdata1_we), .sbdata0_re_i(sbdata0_re),
        .wdata_i(wdata), .sbcs_o(sbcs), .sbaddr_o(sbaddr), .sbdata_o(sbdata),
        .bus_req_o(req), .bus_we_o(we), .bus_addr_o(baddr), .bus_be_o(be),
        .bus_wdata_o(bwdata), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid),
        .bus_rdata_i(rdata), .bus_err_i(berr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_sbcs(input logic [31:0] v);
        sbcs_we = 1'b1; wdata = v; step(); sbcs_we = 1'b0;
    endtask

    task automatic wr_addr0(input logic [31:0] v);
        sbaddr0_we = 1'b1; wdata = v; step(); sbaddr0_we = 1'b0;
    endtask

    task automatic wr_data0(input logic [31:0] v);
        sbdata0_we = 1'b1; wdata = v; step(); sbdata0_we = 1'b0;
    endtask

    task automatic do_gnt();
        gnt = 1'b1; step(); gnt = 1'b0;
    endtask

    task automatic do_rsp(input logic [31:0] d, input logic e);
        rvalid = 1'b1; rdata = d; berr = e; step();
        rvalid = 1'b0; berr = 1'b0; rdata = '0;
    endtask

    initial begin
        rst = 1'b1; dmactive = 1'b1;
        sbcs_we = 0; sbaddr0_we = 0; sbaddr1_we = 0; sbdata0_we = 0; sbdata1_we = 0;
        sbdata0_re = 0; wdata = '0; gnt = 0; rvalid = 0; rdata = '0; berr = 0;
        step(); step();
        rst = 1'b0;
        step();

        // reset image: version 1, sbaccess=2, sbasize=32, sizes 8/16/32
        chk("rst_sbcs", sbcs, 32'h2004_0407);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_addr", sbaddr, 32'h0);
        chk("rst_be", {28'b0, be}, 32'h0);

        // 1: read on address write
        wr_sbcs(32'h0014_0000);
        chk("t1_sbcs", sbcs, 32'h2014_0407);
        wr_addr0(32'h0000_1000);
        chk("t1_req", {31'b0, req}, 32'h1);
        chk("t1_we", {31'b0, we}, 32'h0);
        chk("t1_baddr", baddr, 32'h0000_1000);
        chk("t1_be", {28'b0, be}, 32'hF);
        chk("t1_busy", {31'b0, sbcs[21]}, 32'h1);
        do_gnt();
        chk("t1_req_after_gnt", {31'b0, req}, 32'h0);
        do_rsp(32'hCAFE_F00D, 1'b0);
        chk("t1_data", sbdata, 32'hCAFE_F00D);
        chk("t1_idle_sbcs", sbcs, 32'h2014_0407);

        // 2: byte writes with autoincrement from an odd address
        wr_sbcs(32'h0001_0000);
        wr_addr0(32'h0000_2003);
        chk("t2_no_read", {31'b0, req}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wr_data0(32'h11 * (k + 1));
            chk($sformatf("t2_req%0d", k), {31'b0, req}, 32'h1);
            chk($sformatf("t2_we%0d", k), {31'b0, we}, 32'h1);
            chk($sformatf("t2_addr%0d", k), baddr, 32'h2003 + k);
            chk($sformatf("t2_be%0d", k), {28'b0, be}, {28'b0, be_exp[k]});
            chk($sformatf("t2_wdata%0d", k), bwdata, 32'h0101_0101 * (32'h11 * (k + 1)));
            do_gnt();
            do_rsp(32'h0, 1'b0);
        end
        chk("t2_final_addr", sbaddr, 32'h0000_2007);

        // 3: misaligned halfword -> sberror=3, then W1C
        wr_sbcs(32'h0002_0000);
        wr_addr0(32'h0000_3001);
        wr_data0(32'h0000_0055);
        chk("t3_no_req", {31'b0, req}, 32'h0);
        chk("t3_err", {29'b0, sbcs[14:12]}, 32'h3);
        chk("t3_data_lands", sbdata, 32'h0000_0055);
        wr_sbcs(32'h0002_7000);
        chk("t3_err_clr", {29'b0, sbcs[14:12]}, 32'h0);

        // 4: busy error on second write, then timeout with gnt held low
        wr_sbcs(32'h0004_0000);
        wr_addr0(32'h0000_4000);
        wr_data0(32'hAAAA_0001);
        chk("t4_req", {31'b0, req}, 32'h1);
        wr_data0(32'hBBBB_0002);
        chk("t4_busyerr", {31'b0, sbcs[22]}, 32'h1);
        chk("t4_data_kept", sbdata, 32'hAAAA_0001);
        repeat (253) step();
        chk("t4_req_before_tmo", {31'b0, req}, 32'h1);
        chk("t4_err_before_tmo", {29'b0, sbcs[14:12]}, 32'h0);
        step();
        chk("t4_req_after_tmo", {31'b0, req}, 32'h0);
        chk("t4_err_tmo", {29'b0, sbcs[14:12]}, 32'h1);
        chk("t4_busy_after_tmo", {31'b0, sbcs[21]}, 32'h0);
        wr_sbcs(32'h0044_7000);
        chk("t4_clr_sbcs", sbcs, 32'h2004_0407);

        // 5: bus error on read response
        wr_sbcs(32'h0015_0000);
        wr_addr0(32'h0000_5000);
        chk("t5_req", {31'b0, req}, 32'h1);
        do_gnt();
        do_rsp(32'h1234_5678, 1'b1);
        chk("t5_err", {29'b0, sbcs[14:12]}, 32'h2);
        chk("t5_addr_kept", sbaddr, 32'h0000_5000);
        chk("t5_data_kept", sbdata, 32'hAAAA_0001);
        wr_sbcs(32'h0000_F000);

        // 5b: read-on-data, byte lane 2
        wr_addr0(32'h0000_6002);
        chk("t5b_no_req", {31'b0, req}, 32'h0);
        sbdata0_re = 1'b1; step(); sbdata0_re = 1'b0;
        chk("t5b_req", {31'b0, req}, 32'h1);
        chk("t5b_be", {28'b0, be}, 32'h4);
        do_gnt();
        do_rsp(32'hDDCC_BBAA, 1'b0);
        chk("t5b_data", sbdata, 32'h0000_00CC);

        // 6: dmactive drop in WaitRead, late response ignored
        wr_sbcs(32'h0014_0000);
        wr_addr0(32'h0000_7000);
        do_gnt();
        chk("t6_busy", {31'b0, sbcs[21]}, 32'h1);
        dmactive = 1'b0; step(); dmactive = 1'b1;
        chk("t6_sbcs_reset", sbcs, 32'h2004_0407);
        chk("t6_addr_reset", sbaddr, 32'h0);
        do_rsp(32'hFFFF_FFFF, 1'b0);
        chk("t6_data_after_late", sbdata, 32'h0);
        chk("t6_sbcs_after_late", sbcs, 32'h2004_0407);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
